avalon_ram_responder: RTL

- Avalon-MM slave memory that answers the CPU's bus master: word-addressed RAM, byteenable writes, multi-cycle waitrequest stalls.
- Sits opposite top_level_CPU on the address/read/write/waitrequest/readdata bus.
- A side-band preload port fills program words before and between runs.
- Bus addresses are byte addresses relative to BASE_ADDR, matching the MIPS reset vector.

---
 rtl/ram_pkg.sv | 31 +++
 rtl/ram_stall_ctrl.sv | 55 +++++
 rtl/avalon_ram_responder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the Avalon-MM RAM responder.
// Holds the FSM state type, the default base address, the LFSR seed/taps
// and the byte-lane merge helper used on write commit.
package ram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  // Byte address of word 0 (MIPS reset vector).
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hBFC00000;

  // 16-bit Fibonacci LFSR: taps 16,14,13,11 (1-based) -> bits 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Replace each byte lane of old_word whose byteenable bit is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ram_stall_ctrl.sv
// Stall counter for the RAM responder: loads a stall count when a request is
// accepted and counts it down while the responder sits in WAIT.
// Ports: clk/reset; start (request accepted), tick (one WAIT cycle elapsed);
// start_zero (the count being loaded is 0, skip WAIT), done (last WAIT cycle).
// Optional macro RAM_RANDOM_STALL_EN adds lfsr[1:0] to the stall count.
module ram_stall_ctrl
  import ram_pkg::*;
#(
  parameter int STALL_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic tick,
  output logic start_zero,
  output logic done
);

  logic [4:0] count;
  logic [4:0] load_val;

`ifdef RAM_RANDOM_STALL_EN
  logic [15:0] lfsr;

  // The current LFSR value sets this request's extra stall; it then steps.
  assign load_val = 5'(STALL_CYCLES) + {3'b000, lfsr[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= LFSR_SEED;
    end else if (start) begin
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end
  end
`else
  assign load_val = 5'(STALL_CYCLES);
`endif

  assign start_zero = (load_val == 5'd0);

  // The counter holds the remaining WAIT cycles including the current one,
  // so the final WAIT cycle is the one where it reads 1.
  assign done = (count <= 5'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 5'd0;
    end else if (start) begin
      count <= load_val;
    end else if (tick && count != 5'd0) begin
      count <= count - 5'd1;
    end
  end

endmodule

// File: rtl/avalon_ram_responder.sv
// Avalon-MM slave RAM: word-addressed memory with byteenable writes,
// a programmable waitrequest stall and a side-band preload port.
// Ports: clk, reset (async active-low); bus address/read/write/writedata/
// byteenable in, waitrequest/readdata out; preload_en/addr/data in; fault out.
// Optional macro RAM_RANDOM_STALL_EN randomises the stall via an LFSR.
module avalon_ram_responder
  import ram_pkg::*;
#(
  parameter int          ADDR_W       = 10,
  parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
  parameter int          STALL_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic              waitrequest,
  output logic [31:0]       readdata,
  input  logic              preload_en,
  input  logic [ADDR_W-1:0] preload_addr,
  input  logic [31:0]       preload_data,
  output logic              fault
);

  localparam int DEPTH = 1 << ADDR_W;

  state_t      state;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;
  logic        lat_rd;
  logic        lat_wr;

  logic [31:0] mem [DEPTH];

  logic              req;
  logic              accept;
  logic              go_ack;
  logic              start_zero;
  logic              done;
  logic [31:0]       cur_addr;
  logic              cur_rd;
  logic              cur_wr;
  logic [31:0]       word_off;
  logic [ADDR_W-1:0] cur_idx;
  logic              cur_bad;

  assign req         = read | write;
  assign waitrequest = req && (state != ACK);

  // Preload owns the memory for the cycle, so IDLE defers bus requests.
  assign accept = (state == IDLE) && req && !preload_en;

  // In IDLE the live bus is the request being accepted (needed when a zero
  // stall jumps straight to ACK); afterwards the latched copy is authoritative.
  always_comb begin
    cur_addr = (state == IDLE) ? address : lat_addr;
    cur_rd   = (state == IDLE) ? read    : lat_rd;
    cur_wr   = (state == IDLE) ? write   : lat_wr;
    // Wrap-around subtraction: addresses below the base land far out of range.
    word_off = (cur_addr - BASE_ADDR) >> 2;
    cur_idx  = word_off[ADDR_W-1:0];
    cur_bad  = (cur_addr[1:0] != 2'b00) ||
               (word_off[31:ADDR_W] != '0) ||
               (cur_rd && cur_wr);
  end

  always_comb begin
    go_ack = 1'b0;
    if (accept && start_zero)           go_ack = 1'b1;
    if ((state == WAIT) && req && done) go_ack = 1'b1;
  end

  ram_stall_ctrl #(
    .STALL_CYCLES (STALL_CYCLES)
  ) u_stall (
    .clk        (clk),
    .reset      (reset),
    .start      (accept),
    .tick       (state == WAIT),
    .start_zero (start_zero),
    .done       (done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      lat_rd    <= 1'b0;
      lat_wr    <= 1'b0;
      readdata  <= '0;
      fault     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_addr  <= address;
            lat_wdata <= writedata;
            lat_be    <= byteenable;
            lat_rd    <= read;
            lat_wr    <= write;
            state     <= start_zero ? ACK : WAIT;
          end
        end
        WAIT: begin
          // Master withdrew the request: abandon it without side effects.
          if (!req)      state <= IDLE;
          else if (done) state <= ACK;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase

      // fault is only ever high during the ACK cycle of a bad access.
      fault <= go_ack && cur_bad;
      if (go_ack) begin
        if (cur_bad)     readdata <= '0;
        else if (cur_rd) readdata <= mem[cur_idx];
      end
    end
  end

  // Memory is not reset. The preload write comes last so it wins a collision
  // with a bus write to the same word.
  always_ff @(posedge clk) begin
    if ((state == ACK) && lat_wr && !cur_bad) begin
      mem[cur_idx] <= merge_bytes(mem[cur_idx], lat_wdata, lat_be);
    end
    if (preload_en) begin
      mem[preload_addr] <= preload_data;
    end
  end

endmodule
